// File: rtl/button_debouncer.sv
// Push-button front end: two-flop synchroniser, bounce filter and
// press / release / long-press event generation with a 6-bit press counter.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES   = 270000,
    parameter int LONG_PRESS_CYCLES = 27000000,
    parameter int ACTIVE_LOW        = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_in,
    output logic       pressed,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_press,
    output logic [5:0] press_count
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);

    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_PRESS_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);
    localparam logic          IDLE_LEVEL = (ACTIVE_LOW != 0);

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    state_t        state;
    logic          sync1;
    logic          sync2;
    logic          btn_s;
    logic          release_now;
    logic          holding;
    logic [DW-1:0] db_cnt;
    logic [HW-1:0] hold_cnt;

    // Normalised synchronised level: 1 means the button is pressed.
    assign btn_s = sync2 ^ IDLE_LEVEL;

    assign holding     = (state == PRESSED) || (state == RELEASE_WAIT);
    assign release_now = (state == RELEASE_WAIT) && !btn_s
                         && (db_cnt == DB_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= RELEASED;
            sync1         <= IDLE_LEVEL;
            sync2         <= IDLE_LEVEL;
            db_cnt        <= '0;
            hold_cnt      <= '0;
            pressed       <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_press    <= 1'b0;
            press_count   <= '0;
        end else begin
            sync1         <= btn_in;
            sync2         <= sync1;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_press    <= 1'b0;

            // Saturating hold timer; an accepted release suppresses long_press.
            if (holding && (hold_cnt < HOLD_MAX)) begin
                hold_cnt <= hold_cnt + 1'b1;
                if ((hold_cnt == HOLD_LAST) && !release_now) begin
                    long_press <= 1'b1;
                end
            end

            unique case (state)
                RELEASED: begin
                    if (btn_s) begin
                        state  <= PRESS_WAIT;
                        db_cnt <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!btn_s) begin
                        state <= RELEASED;
                    end else if (db_cnt == DB_LAST) begin
                        state       <= PRESSED;
                        pressed     <= 1'b1;
                        press_pulse <= 1'b1;
                        press_count <= press_count + 6'd1;
                        hold_cnt    <= '0;
                    end else begin
                        db_cnt <= db_cnt + 1'b1;
                    end
                end
                PRESSED: begin
                    if (!btn_s) begin
                        state  <= RELEASE_WAIT;
                        db_cnt <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (btn_s) begin
                        state <= PRESSED;
                    end else if (db_cnt == DB_LAST) begin
                        state         <= RELEASED;
                        pressed       <= 1'b0;
                        release_pulse <= 1'b1;
                    end else begin
                        db_cnt <= db_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= RELEASED;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: directed scenarios plus random pin activity,
// every cycle compared against a run-length reference model.
module tb_button_debouncer;

    localparam int D = 4;
    localparam int L = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_in = 1'b1;
    logic       pressed;
    logic       press_pulse;
    logic       release_pulse;
    logic       long_press;
    logic [5:0] press_count;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic       m_s1, m_s2, m_deb;
    logic       m_pp, m_rp, m_lp;
    int         m_run, m_age;
    logic [5:0] m_cnt;

    always #5 clk = ~clk;

    button_debouncer #(
        .DEBOUNCE_CYCLES(D),
        .LONG_PRESS_CYCLES(L),
        .ACTIVE_LOW(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_in(btn_in),
        .pressed(pressed),
        .press_pulse(press_pulse),
        .release_pulse(release_pulse),
        .long_press(long_press),
        .press_count(press_count)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // A level change is accepted once the synchronised level has differed
    // from the debounced level for D+1 consecutive edges.
    task automatic model_edge();
        logic bs;
        logic prev;
        if (rst) begin
            m_s1 = 1'b0; m_s2 = 1'b0; m_deb = 1'b0;
            m_pp = 1'b0; m_rp = 1'b0; m_lp = 1'b0;
            m_run = 0; m_age = 0; m_cnt = '0;
            return;
        end
        bs   = m_s2;
        m_s2 = m_s1;
        m_s1 = ~btn_in;
        m_pp = 1'b0; m_rp = 1'b0; m_lp = 1'b0;
        prev = m_deb;
        if (bs != m_deb) begin
            m_run++;
            if (m_run == D + 1) begin
                m_deb = bs;
                m_run = 0;
                if (bs) begin
                    m_pp  = 1'b1;
                    m_cnt = m_cnt + 6'd1;
                end else begin
                    m_rp = 1'b1;
                end
            end
        end else begin
            m_run = 0;
        end
        if (prev && m_age < L) begin
            m_age++;
            if (m_age == L && !m_rp) m_lp = 1'b1;
        end
        if (m_pp) m_age = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("pressed", {31'd0, pressed}, {31'd0, m_deb});
        check("press_pulse", {31'd0, press_pulse}, {31'd0, m_pp});
        check("release_pulse", {31'd0, release_pulse}, {31'd0, m_rp});
        check("long_press", {31'd0, long_press}, {31'd0, m_lp});
        check("press_count", {26'd0, press_count}, {26'd0, m_cnt});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        btn_in = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // which: 0 press_pulse, 1 release_pulse, 2 long_press
    task automatic wait_pulse(input int which, input int maxn,
                              output int k, output int nlong);
        logic hit;
        k = -1;
        nlong = 0;
        for (int i = 1; i <= maxn; i++) begin
            tick();
            if (long_press) nlong++;
            hit = (which == 0) ? press_pulse :
                  (which == 1) ? release_pulse : long_press;
            if (hit) begin
                k = i;
                break;
            end
        end
    endtask

    int k, nl, len;

    initial begin
        // Reset state
        tick();
        check("rst_pressed", {31'd0, pressed}, 32'd0);
        check("rst_count", {26'd0, press_count}, 32'd0);
        rst = 1'b0;
        repeat (3) tick();

        // 1. Clean press
        btn_in = 1'b0;
        wait_pulse(0, 20, k, nl);
        check("t1_latency", k, 32'd7);
        tick();
        check("t1_pressed", {31'd0, pressed}, 32'd1);
        check("t1_count", {26'd0, press_count}, 32'd1);

        // 2. Bounce rejected
        do_reset();
        btn_in = 1'b0;
        repeat (3) tick();
        btn_in = 1'b1;
        repeat (2) tick();
        check("t2_no_early", {26'd0, press_count}, 32'd0);
        btn_in = 1'b0;
        wait_pulse(0, 20, k, nl);
        check("t2_latency", k, 32'd7);
        check("t2_count", {26'd0, press_count}, 32'd1);

        // 3. Long press then release
        do_reset();
        btn_in = 1'b0;
        wait_pulse(0, 20, k, nl);
        check("t3_press", k, 32'd7);
        wait_pulse(2, 30, k, nl);
        check("t3_long_latency", k, 32'd10);
        wait_pulse(2, 20, k, nl);
        check("t3_long_once", k, 32'hFFFF_FFFF);
        btn_in = 1'b1;
        wait_pulse(1, 20, k, nl);
        check("t3_rel_latency", k, 32'd7);
        check("t3_pressed", {31'd0, pressed}, 32'd0);

        // 4. Release accepted on the long-press threshold edge
        do_reset();
        btn_in = 1'b0;
        wait_pulse(0, 20, k, nl);
        check("t4_press", k, 32'd7);
        repeat (3) tick();
        check("t4_no_long_yet", {31'd0, long_press}, 32'd0);
        btn_in = 1'b1;
        wait_pulse(1, 20, k, nl);
        check("t4_rel_latency", k, 32'd7);
        check("t4_long_before", nl, 32'd0);
        wait_pulse(2, 20, k, nl);
        check("t4_long_after", k, 32'hFFFF_FFFF);

        // 5. press_count wrap-around
        do_reset();
        for (int i = 0; i < 64; i++) begin
            btn_in = 1'b0;
            wait_pulse(0, 20, k, nl);
            check("t5_press", k, 32'd7);
            check("t5_count", {26'd0, press_count}, (i + 1) % 64);
            btn_in = 1'b1;
            wait_pulse(1, 20, k, nl);
            check("t5_release", k, 32'd7);
        end

        // 6. Reset while held
        do_reset();
        btn_in = 1'b0;
        wait_pulse(0, 20, k, nl);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_pressed", {31'd0, pressed}, 32'd0);
        check("t6_count", {26'd0, press_count}, 32'd0);
        wait_pulse(0, 20, k, nl);
        check("t6_latency", k, 32'd7);
        check("t6_count_after", {26'd0, press_count}, 32'd1);

        // Random pin activity with occasional resets
        do_reset();
        for (int seg = 0; seg < 400; seg++) begin
            btn_in = 1'($urandom_range(1, 0));
            if ($urandom_range(7, 0) == 0) len = $urandom_range(40, 15);
            else len = $urandom_range(8, 1);
            for (int c = 0; c < len; c++) begin
                rst = ($urandom_range(299, 0) == 0);
                tick();
            end
        end
        rst = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
